// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end branch predictor blocks.
//
// Contents:
//   bp_fe_bht_state_e                    BHT init-sweep / ready state encoding
//   DECLARE_BP_FE_BHT_UPDATE_S(width)    macro that declares the update
//                                        record {idx, correct} for a given
//                                        index width. The index width is a
//                                        per-instance parameter, so the struct
//                                        cannot live in the package itself.

`define DECLARE_BP_FE_BHT_UPDATE_S(idx_width_mp) \
  typedef struct packed { \
    logic [idx_width_mp-1:0] idx; \
    logic                    correct; \
  } bp_fe_bht_update_s

package bp_fe_pkg;

  typedef enum logic {
    e_clear = 1'b0,
    e_ready = 1'b1
  } bp_fe_bht_state_e;

endpackage

// File: rtl/bp_fe_bht_sat_ctr.sv
// Combinational next-state logic for one saturating branch counter.
// The counter MSB is the taken/not-taken prediction. A correct prediction
// strengthens the current direction; an incorrect one moves toward the
// other direction. Both ends saturate.
//
// Ports:
//   ctr_i      current counter value
//   correct_i  the prediction made from ctr_i was correct
//   ctr_o      next counter value

module bp_fe_bht_sat_ctr
  import bp_fe_pkg::*;
#(
  parameter int ctr_width_p = 2
) (
  input  logic [ctr_width_p-1:0] ctr_i,
  input  logic                   correct_i,
  output logic [ctr_width_p-1:0] ctr_o
);

  localparam logic [ctr_width_p-1:0] max_lp = '1;
  localparam logic [ctr_width_p-1:0] one_lp = ctr_width_p'(1);

  // Moving up is right when a taken prediction was correct or a not-taken
  // prediction was wrong, i.e. whenever correct_i matches the MSB.
  logic w_inc;
  assign w_inc = (correct_i == ctr_i[ctr_width_p-1]);

  // The incorrect cases can never hit a rail (the MSB keeps c away from the
  // end it moves toward), so the saturation tests only matter for correct.
  always_comb begin
    ctr_o = ctr_i;
    if (w_inc) begin
      if (ctr_i != max_lp) ctr_o = ctr_i + one_lp;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - one_lp;
    end
  end

endmodule

// File: rtl/bp_fe_bht.sv
// Branch history table: one saturating counter per index.
//
// After reset an init sweep writes init_val_p into every entry, one per
// cycle, then the table serves lookups and resolution updates.
//
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   init_done_o              sweep finished, table usable
//   r_v_i, idx_r_i           lookup request and index
//   predict_v_o, predict_o   registered prediction, one cycle after lookup
//   w_v_i, idx_w_i,
//   correct_i                resolution update request
//   w_yumi_o                 update accepted this cycle

module bp_fe_bht
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = 9,
  parameter int ctr_width_p     = 2,
  parameter int init_val_p      = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic                       correct_i,
  output logic                       w_yumi_o
);

  localparam int                     els_lp     = 2**bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] initVal_lp = ctr_width_p'(init_val_p);

  `DECLARE_BP_FE_BHT_UPDATE_S(bht_idx_width_p);

  bp_fe_bht_state_e          r_state, w_stateNext;
  logic [bht_idx_width_p-1:0] r_ptr;
  logic [ctr_width_p-1:0]     r_ctrMem [els_lp];

  logic                   r_s2Valid;
  bp_fe_bht_update_s      r_s2Upd;
  logic [ctr_width_p-1:0] r_s2Ctr;
  logic [ctr_width_p-1:0] w_s2NextCtr;
  logic [ctr_width_p-1:0] w_updReadCtr;
  logic [ctr_width_p-1:0] w_lookupCtr;
  logic                   w_s2HitUpd;
  logic                   w_s2HitLookup;

  assign init_done_o = (r_state == e_ready);
  assign w_yumi_o    = w_v_i & init_done_o;

  // Sweep ends on the last index; its write still happens in that cycle.
  always_comb begin
    w_stateNext = r_state;
    if ((r_state == e_clear) && (&r_ptr)) w_stateNext = e_ready;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_clear;
      r_ptr   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == e_clear) r_ptr <= r_ptr + 1'b1;
    end
  end

  // Stage 2 computes the new counter from the value captured in stage 1.
  bp_fe_bht_sat_ctr #(
    .ctr_width_p(ctr_width_p)
  ) u_satCtr (
    .ctr_i    (r_s2Ctr),
    .correct_i(r_s2Upd.correct),
    .ctr_o    (w_s2NextCtr)
  );

  // Both read ports see the value stage 2 is writing this cycle, so a
  // back-to-back update or a lookup of the same index is never stale.
  assign w_s2HitUpd    = r_s2Valid && (r_s2Upd.idx == idx_w_i);
  assign w_s2HitLookup = r_s2Valid && (r_s2Upd.idx == idx_r_i);
  assign w_updReadCtr  = w_s2HitUpd    ? w_s2NextCtr : r_ctrMem[idx_w_i];
  assign w_lookupCtr   = w_s2HitLookup ? w_s2NextCtr : r_ctrMem[idx_r_i];

  // Reset clears r_s2Valid, which is what drops an in-flight write.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s2Valid <= 1'b0;
      r_s2Upd   <= '0;
      r_s2Ctr   <= '0;
    end else begin
      r_s2Valid <= w_yumi_o;
      if (w_yumi_o) begin
        r_s2Upd <= '{idx: idx_w_i, correct: correct_i};
        r_s2Ctr <= w_updReadCtr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      predict_v_o <= 1'b0;
      predict_o   <= 1'b0;
    end else begin
      predict_v_o <= r_v_i & init_done_o;
      predict_o   <= r_v_i & init_done_o & w_lookupCtr[ctr_width_p-1];
    end
  end

  // Single write port shared by the sweep and stage 2; they never overlap
  // because updates are only accepted once the sweep is done.
  always_ff @(posedge clk_i) begin
    if (r_state == e_clear) begin
      r_ctrMem[r_ptr] <= initVal_lp;
    end else if (r_s2Valid) begin
      r_ctrMem[r_s2Upd.idx] <= w_s2NextCtr;
    end
  end

endmodule

// File: tb/tb_bp_fe_bht.sv
// Self-checking bench for bp_fe_bht with a 16-entry table of 2-bit counters.
// Lookup expectations go into a queue when the lookup is driven and are
// popped by a monitor when predict_v_o shows up.

module tb_bp_fe_bht;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       init_done_o;
  logic       r_v_i;
  logic [3:0] idx_r_i;
  logic       predict_v_o;
  logic       predict_o;
  logic       w_v_i;
  logic [3:0] idx_w_i;
  logic       correct_i;
  logic       w_yumi_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [1:0] model [16];
  logic       benchReady;
  logic       expQ [$];

  typedef struct {
    logic       rv;
    logic [3:0] ridx;
    logic       wv;
    logic [3:0] widx;
    logic       corr;
    logic       expPred;
  } vec_t;

  vec_t vecs [12];

  always #5 clk_i = ~clk_i;

  bp_fe_bht #(
    .bht_idx_width_p(4),
    .ctr_width_p    (2),
    .init_val_p     (1)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .init_done_o(init_done_o),
    .r_v_i      (r_v_i),
    .idx_r_i    (idx_r_i),
    .predict_v_o(predict_v_o),
    .predict_o  (predict_o),
    .w_v_i      (w_v_i),
    .idx_w_i    (idx_w_i),
    .correct_i  (correct_i),
    .w_yumi_o   (w_yumi_o)
  );

  // Counter rule written straight from the direction/saturation table.
  function automatic logic [1:0] modelNext(input logic [1:0] c, input logic corr);
    if (corr && c[1])  return (c == 2'd3) ? 2'd3 : c + 2'd1;
    if (corr && !c[1]) return (c == 2'd0) ? 2'd0 : c - 2'd1;
    if (!corr && c[1]) return c - 2'd1;
    return c + 2'd1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus. An accepted update becomes visible to lookups
  // from the next cycle on, so the expected lookup result is taken from the
  // model before this cycle's update is applied.
  task automatic applyStimulus(input logic rv, input logic [3:0] ridx,
                               input logic wv, input logic [3:0] widx,
                               input logic corr, input logic useExp,
                               input logic expPred);
    @(negedge clk_i);
    #1;
    r_v_i     = rv;
    idx_r_i   = ridx;
    w_v_i     = wv;
    idx_w_i   = widx;
    correct_i = corr;
    if (rv && benchReady) expQ.push_back(useExp ? expPred : model[ridx][1]);
    #1;
    checkOutput("w_yumi", int'(w_yumi_o), int'(wv && benchReady));
    if (wv && benchReady) model[widx] = modelNext(model[widx], corr);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enterReset();
    reset_n_i = 1'b0;
    expQ.delete();
    benchReady = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 2'd1;
  endtask

  // Counts cycles from reset release to init_done_o, watching that nothing
  // is accepted or predicted while the sweep runs.
  task automatic waitInit(input string tag);
    int  cycles;
    logic early;
    cycles = 0;
    early  = 1'b0;
    while (!init_done_o && cycles < 40) begin
      @(posedge clk_i);
      #1;
      cycles++;
      if (!init_done_o && (w_yumi_o || predict_v_o)) early = 1'b1;
    end
    checkOutput({tag, "_init_cycles"}, cycles, 16);
    checkOutput({tag, "_busy_during_clear"}, int'(early), 0);
    r_v_i = 1'b0;
    benchReady = 1'b1;
  endtask

  always @(negedge clk_i) begin
    logic e;
    if (predict_v_o) begin
      if (expQ.size() == 0) begin
        checkOutput("predict_unexpected", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("predict_o", int'(predict_o), int'(e));
      end
    end else begin
      checkOutput("predict_idle_zero", int'(predict_o), 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b1, 1'b1};
    vecs[2]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b1, 1'b1};
    vecs[3]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 1'b1};
    vecs[4]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd3,  1'b0, 4'd0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd10, 1'b1, 4'd10, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd10, 1'b1, 4'd10, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 4'd10, 1'b0, 4'd0,  1'b0, 1'b0};

    r_v_i     = 1'b0;
    idx_r_i   = 4'd0;
    w_v_i     = 1'b1;
    idx_w_i   = 4'd12;
    correct_i = 1'b0;
    enterReset();

    #12;
    checkOutput("reset_init_done", int'(init_done_o), 0);
    checkOutput("reset_predict_v", int'(predict_v_o), 0);
    checkOutput("reset_predict", int'(predict_o), 0);
    checkOutput("reset_yumi", int'(w_yumi_o), 0);

    // Update held from reset release: accepted on the first ready cycle.
    @(negedge clk_i);
    #3 reset_n_i = 1'b1;
    waitInit("first");
    checkOutput("held_update_yumi", int'(w_yumi_o), 1);
    model[12] = modelNext(model[12], 1'b0);
    @(posedge clk_i);
    #1 w_v_i = 1'b0;
    idleCycle();
    applyStimulus(1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].ridx, vecs[i].wv, vecs[i].widx,
                    vecs[i].corr, 1'b1, vecs[i].expPred);
    end

    // Back-to-back incorrect updates on index 5 go through the bypass.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("ctr5_after_b2b", int'(dut.r_ctrMem[5]), int'(model[5]));
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Lookup of index 7 in the same cycle stage 2 writes it.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    idleCycle();

    // Reset in the middle of the sweep with a lookup pending.
    @(negedge clk_i);
    enterReset();
    #3 reset_n_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #2;
    checkOutput("midsweep_ptr", int'(dut.r_ptr), 8);
    r_v_i = 1'b1;
    #1 reset_n_i = 1'b0;
    #1;
    checkOutput("midsweep_init_done", int'(init_done_o), 0);
    checkOutput("midsweep_predict_v", int'(predict_v_o), 0);
    @(negedge clk_i);
    #3 reset_n_i = 1'b1;
    waitInit("midsweep");

    // Reset with a lookup result and an update write both in flight.
    applyStimulus(1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #2;
    r_v_i = 1'b0;
    w_v_i = 1'b0;
    enterReset();
    #1;
    checkOutput("inflight_predict_v", int'(predict_v_o), 0);
    checkOutput("inflight_init_done", int'(init_done_o), 0);
    @(negedge clk_i);
    #3 reset_n_i = 1'b1;
    waitInit("inflight");
    checkOutput("ctr6_write_dropped", int'(dut.r_ctrMem[6]), 1);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    end
    idleCycle();
    idleCycle();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
